// File: rtl/pokey_serial_pkg.sv
// Shared types and constants for the POKEY serial output channel.
package pokey_serial_pkg;

    localparam int unsigned FRAME_DATA_BITS = 8;
    localparam int unsigned TICK_CNT_W      = 4;
    localparam int unsigned BIT_IDX_W       = 3;
    localparam logic        SOD_IDLE        = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    typedef logic [FRAME_DATA_BITS-1:0] ser_byte_t;

    // Line level of the undecorated serial stream for a given shifter state.
    function automatic logic raw_serial_bit(input tx_state_e s, input logic lsb);
        case (s)
            START:   return 1'b0;
            DATA:    return lsb;
            default: return SOD_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/pokey_serial_tx_if.sv
// SEROUT register write port and transmitter status seen by the CPU/IRQ side.
interface pokey_serial_tx_if;
    import pokey_serial_pkg::*;

    logic      wr_en;
    ser_byte_t data_in;
    logic      busy;
    logic      serout_needed;
    logic      xmit_done;

    modport master (output wr_en, output data_in,
                    input  busy, input serout_needed, input xmit_done);
    modport slave  (input  wr_en, input data_in,
                    output busy, output serout_needed, output xmit_done);
endinterface

// File: rtl/pokey_bit_timer.sv
// Counts timer underflow ticks and flags the tick that completes a serial bit.
module pokey_bit_timer
    import pokey_serial_pkg::*;
#(
    parameter int unsigned TICKS_PER_BIT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic tick,
    input  logic clear,
    output logic bit_done_c
);

    localparam logic [TICK_CNT_W-1:0] LAST_TICK = TICK_CNT_W'(TICKS_PER_BIT - 1);

    logic [TICK_CNT_W-1:0] cnt;

    // Not gated by clear, so the transfer decision can depend on it without a loop.
    assign bit_done_c = en && tick && (cnt == LAST_TICK);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en && tick) begin
            cnt <= bit_done_c ? '0 : cnt + TICK_CNT_W'(1);
        end
    end

endmodule

// File: rtl/pokey_serial_tx.sv
// POKEY SEROUT channel: holding register, start/8-data/stop shifter, IRQ sources.
// Define POKEY_TWO_TONE_EN to add the two-tone (tone_en/tone_a/tone_b) output modulation.
module pokey_serial_tx
    import pokey_serial_pkg::*;
#(
    parameter int unsigned TICKS_PER_BIT = 2
) (
    input  logic               clk,
    input  logic               reset,
    pokey_serial_tx_if.slave   ser,
    input  logic               bit_tick,
    input  logic               force_break,
`ifdef POKEY_TWO_TONE_EN
    input  logic               tone_en,
    input  logic               tone_a,
    input  logic               tone_b,
`endif
    output logic               sod
);

    tx_state_e              state_q, state_d;
    ser_byte_t              hold_q, hold_d;
    ser_byte_t              shift_q, shift_d;
    logic                   hold_full_q, hold_full_d;
    logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;

    logic transfer_c;
    logic bit_done_c;
    logic timing_en_c;
    logic raw_c;
    logic line_c;
    logic sod_d;

    logic busy_q;
    logic serout_needed_q;
    logic xmit_done_q;

    assign timing_en_c = (state_q != IDLE);

    pokey_bit_timer #(
        .TICKS_PER_BIT (TICKS_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .reset      (reset),
        .en         (timing_en_c),
        .tick       (bit_tick),
        .clear      (transfer_c),
        .bit_done_c (bit_done_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            hold_q          <= '0;
            shift_q         <= '0;
            hold_full_q     <= 1'b0;
            bit_idx_q       <= '0;
            sod             <= SOD_IDLE;
            busy_q          <= 1'b0;
            serout_needed_q <= 1'b0;
            xmit_done_q     <= 1'b1;
        end else begin
            state_q         <= state_d;
            hold_q          <= hold_d;
            shift_q         <= shift_d;
            hold_full_q     <= hold_full_d;
            bit_idx_q       <= bit_idx_d;
            sod             <= sod_d;
            busy_q          <= (state_d != IDLE);
            serout_needed_q <= transfer_c;
            xmit_done_q     <= (state_d == IDLE) && !hold_full_d;
        end
    end

    // Next-state: frame sequencing, then hold->shifter transfer, then CPU write.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        shift_d     = shift_q;
        hold_full_d = hold_full_q;
        bit_idx_d   = bit_idx_q;
        transfer_c  = 1'b0;

        case (state_q)
            IDLE: ;
            START: begin
                if (bit_done_c) state_d = DATA;
            end
            DATA: begin
                if (bit_done_c) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    if (bit_idx_q == BIT_IDX_W'(FRAME_DATA_BITS - 1)) state_d = STOP;
                end
            end
            STOP: begin
                if (bit_done_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        transfer_c = hold_full_q && ((state_q == IDLE) || ((state_q == STOP) && bit_done_c));
        if (transfer_c) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            state_d     = START;
            bit_idx_d   = '0;
        end

        // A write landing with a transfer refills hold after the old byte moved out.
        if (ser.wr_en) begin
            hold_d      = ser.data_in;
            hold_full_d = 1'b1;
        end

        raw_c = raw_serial_bit(state_d, shift_d[0]);
`ifdef POKEY_TWO_TONE_EN
        line_c = tone_en ? (raw_c ? tone_a : tone_b) : raw_c;
`else
        line_c = raw_c;
`endif
        sod_d = force_break ? 1'b0 : line_c;
    end

    assign ser.busy          = busy_q;
    assign ser.serout_needed = serout_needed_q;
    assign ser.xmit_done     = xmit_done_q;

endmodule
